frame_scanner: RTL and testbench
================================

FRAME_SCANNER -- requirements
Module: frame_scanner

Interface
REQ-001 SHALL have parameter H_VISIBLE, 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, 16; H_SYNC, 96; H_BACK, 48, horizontal porch/sync widths in pixel ticks (line total 800).
REQ-003 SHALL have parameter V_VISIBLE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33, vertical widths in lines (frame total 525).
REQ-004 SHALL have parameter SCALE_SHIFT, 2, log2 of display pixels per framebuffer pixel (640x480 over 160x120).
REQ-005 SHALL have port Clck  input  1  system clock, 50 MHz.
REQ-006 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port mem_address  output  MEMORY_SIZE_BITS  framebuffer read address.
REQ-008 SHALL have port mem_color  input  3  framebuffer read data {R,G,B}, valid one Clck after mem_address.
REQ-009 SHALL have port vga_r, vga_g, vga_b  output  1 each  pixel colour.
REQ-010 SHALL have port vga_hs, vga_vs  output  1 each  syncs, active-low.
REQ-011 SHALL have port vga_blank_n  output  1  high during visible region.
REQ-012 SHALL have port frame_tick  output  1  one-Clck pulse at first blanking line after last visible line (painter start window).

Function
REQ-013 SHALL derive pixel tick pix_en toggling every Clck (25 MHz effective); all counters advance only when pix_en=1.
REQ-014 SHALL count h_cnt 0..799, wrapping to 0 and incrementing v_cnt; v_cnt 0..524 wraps to 0.
REQ-015 SHALL assert hsync (pre-pipeline) when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC; vsync likewise on v_cnt.
REQ-016 SHALL define visible = (h_cnt < H_VISIBLE) and (v_cnt < V_VISIBLE).
REQ-017 SHALL drive mem_address = MAP_PIXELCO_MEMADDR(h_cnt >> SCALE_SHIFT, v_cnt >> SCALE_SHIFT), registered, updated on the pix_en cycle.
REQ-018 SHALL capture mem_color on the next pix_en cycle; colour outputs, syncs and blank_n SHALL all be delayed exactly one pixel tick so they stay aligned.
REQ-019 SHALL force vga_r/g/b to 0 whenever the delayed visible flag is 0, regardless of mem_color.
REQ-020 SHALL hold mem_address at its last visible value outside the visible region (no reads of out-of-range addresses).
REQ-021 SHALL pulse frame_tick for exactly one Clck when v_cnt becomes V_VISIBLE with h_cnt=0.
REQ-022 SHALL be read-only toward the framebuffer; concurrent writes from the painter are permitted, and a pixel written in the same Clck as its read SHALL show either old or new colour (no X).
REQ-023 SHALL use widths SCR_WIDTH_BITS/SCR_HEIGHT_BITS for framebuffer coordinates; h_cnt/v_cnt 10 bits each.

Reset
REQ-024 SHALL, on Reset=0 (async), clear h_cnt, v_cnt, pix_en, mem_address, colour outputs, vga_blank_n and frame_tick to 0, and set vga_hs=vga_vs=1.
REQ-025 SHALL, on Reset release mid-frame, restart at h_cnt=v_cnt=0 with the first mem_address issued on the first pix_en cycle.
REQ-026 SHALL make Reset deassertion take effect on the next Clck edge only (synchronous release).

Structure
REQ-027 SHALL take SCR_WIDTH_BITS, SCR_HEIGHT_BITS, MEMORY_SIZE_BITS, MAP_PIXELCO_MEMADDR and colour codes from the shared header.
REQ-028 SHALL keep timing parameters local to the module.
REQ-029 SHALL contain one sub-module vga_timing (counters, sync and visible generation); fetch and output pipeline in the top.

Verification
REQ-030 After reset release, count Clck between vga_hs falling edges -> 1600; vga_hs low width -> 192 Clck.
REQ-031 Count vga_hs pulses between vga_vs falling edges -> 525; vga_vs low width -> 2 lines (3200 Clck).
REQ-032 Framebuffer model fills address k with colour k%8; at display pixel (x=8,y=4) -> mem_address = MAP_PIXELCO_MEMADDR(2,1), colour on output one pixel tick later with blank_n=1.
REQ-033 Framebuffer all 3'b111 -> during h_cnt 640..799 outputs r=g=b=0, blank_n=0; frame_tick high exactly 1 Clck per frame, at v_cnt=480.
REQ-034 Assert Reset=0 at h_cnt=300, v_cnt=200 -> all outputs at reset values same cycle; release -> next hsync falling edge 656 pixel ticks later.
REQ-035 Painter writes pixel (10,10) to 3'b001 while scanning -> next frame shows blue at display pixels x 40..43, y 40..43.

Source files
------------

// File: rtl/frame_scanner_pkg.sv
// Shared framebuffer geometry, colour codes and the pixel-to-address map used by
// the scanner and the painter side of the framebuffer.
package frame_scanner_pkg;

  localparam int SCR_WIDTH        = 160;
  localparam int SCR_WIDTH_BITS   = 8;
  localparam int SCR_HEIGHT_BITS  = 7;
  localparam int MEMORY_SIZE_BITS = 15;
  localparam int CNT_BITS         = 10;

  localparam logic [2:0] COLOR_BLACK = 3'b000;

  // Raw (pre-pipeline) timing state; hsync/vsync here are active-high "in pulse".
  typedef struct packed {
    logic [CNT_BITS-1:0] h_cnt;
    logic [CNT_BITS-1:0] v_cnt;
    logic                hsync;
    logic                vsync;
    logic                visible;
    logic                frame_end;
  } timing_t;

  function automatic logic [MEMORY_SIZE_BITS-1:0] MAP_PIXELCO_MEMADDR(
    input logic [SCR_WIDTH_BITS-1:0]  x,
    input logic [SCR_HEIGHT_BITS-1:0] y
  );
    return MEMORY_SIZE_BITS'(y) * MEMORY_SIZE_BITS'(SCR_WIDTH) + MEMORY_SIZE_BITS'(x);
  endfunction

endpackage

// File: rtl/frame_scanner_timing.sv
// Horizontal/vertical pixel counters with sync and visible-region decode.
// Counters only move on pixel ticks; all outputs are decoded from the live counts.
module vga_timing
  import frame_scanner_pkg::*;
#(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_pix_en,
  output timing_t o_tim
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  logic [CNT_BITS-1:0] r_h_cnt;
  logic [CNT_BITS-1:0] r_v_cnt;
  logic                w_h_last;

  assign w_h_last = (r_h_cnt == CNT_BITS'(H_TOTAL - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_pix_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        if (r_v_cnt == CNT_BITS'(V_TOTAL - 1)) r_v_cnt <= '0;
        else                                   r_v_cnt <= r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    o_tim.h_cnt   = r_h_cnt;
    o_tim.v_cnt   = r_v_cnt;
    o_tim.hsync   = (r_h_cnt >= CNT_BITS'(H_VISIBLE + H_FRONT)) &&
                    (r_h_cnt <  CNT_BITS'(H_VISIBLE + H_FRONT + H_SYNC));
    o_tim.vsync   = (r_v_cnt >= CNT_BITS'(V_VISIBLE + V_FRONT)) &&
                    (r_v_cnt <  CNT_BITS'(V_VISIBLE + V_FRONT + V_SYNC));
    o_tim.visible = (r_h_cnt < CNT_BITS'(H_VISIBLE)) && (r_v_cnt < CNT_BITS'(V_VISIBLE));
    // Last pixel of the last visible line: the next tick lands on (0, V_VISIBLE).
    o_tim.frame_end = w_h_last && (r_v_cnt == CNT_BITS'(V_VISIBLE - 1));
  end

endmodule

// File: rtl/frame_scanner.sv
// VGA scan-out of a scaled framebuffer: pixel tick, address fetch and a one-tick
// output pipeline that keeps colour, syncs and blank_n aligned with the read data.
module frame_scanner
  import frame_scanner_pkg::*;
#(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SCALE_SHIFT = 2
) (
  input  logic                        Clck,
  input  logic                        Reset,
  output logic [MEMORY_SIZE_BITS-1:0] mem_address,
  input  logic [2:0]                  mem_color,
  output logic                        vga_r,
  output logic                        vga_g,
  output logic                        vga_b,
  output logic                        vga_hs,
  output logic                        vga_vs,
  output logic                        vga_blank_n,
  output logic                        frame_tick
);

  logic                        r_pix_en;
  timing_t                     w_tim;
  logic [SCR_WIDTH_BITS-1:0]   w_fb_x;
  logic [SCR_HEIGHT_BITS-1:0]  w_fb_y;
  logic [MEMORY_SIZE_BITS-1:0] r_mem_address;
  logic                        r_hs_d;
  logic                        r_vs_d;
  logic                        r_vis_d;
  logic [2:0]                  r_rgb;
  logic                        r_hs;
  logic                        r_vs;
  logic                        r_blank_n;
  logic                        r_frame_tick;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .i_clk    (Clck),
    .i_rst_n  (Reset),
    .i_pix_en (r_pix_en),
    .o_tim    (w_tim)
  );

  assign w_fb_x = SCR_WIDTH_BITS'(w_tim.h_cnt >> SCALE_SHIFT);
  assign w_fb_y = SCR_HEIGHT_BITS'(w_tim.v_cnt >> SCALE_SHIFT);

  // Stage 1 (tick k): issue address for pixel k and latch its sync/visible flags.
  // Stage 2 (tick k+1): read data for pixel k is back; emit it with those flags.
  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      r_pix_en      <= 1'b0;
      r_mem_address <= '0;
      r_hs_d        <= 1'b1;
      r_vs_d        <= 1'b1;
      r_vis_d       <= 1'b0;
      r_rgb         <= COLOR_BLACK;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank_n     <= 1'b0;
      r_frame_tick  <= 1'b0;
    end else begin
      r_pix_en     <= ~r_pix_en;
      r_frame_tick <= r_pix_en & w_tim.frame_end;
      if (r_pix_en) begin
        // Address freezes outside the visible area so no out-of-range reads occur.
        if (w_tim.visible) r_mem_address <= MAP_PIXELCO_MEMADDR(w_fb_x, w_fb_y);
        r_hs_d    <= ~w_tim.hsync;
        r_vs_d    <= ~w_tim.vsync;
        r_vis_d   <= w_tim.visible;
        r_rgb     <= r_vis_d ? mem_color : COLOR_BLACK;
        r_hs      <= r_hs_d;
        r_vs      <= r_vs_d;
        r_blank_n <= r_vis_d;
      end
    end
  end

  assign mem_address = r_mem_address;
  assign vga_r       = r_rgb[2];
  assign vga_g       = r_rgb[1];
  assign vga_b       = r_rgb[0];
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_blank_n;
  assign frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_frame_scanner.sv
// Bench for frame_scanner: a full-size instance for line timing and addressing, and
// a shrunken-timing instance checked every clock against a tick-count reference model.
module tb_frame_scanner;

  localparam int S_HV = 16, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VV = 12, S_VF = 2, S_VS = 2, S_VB = 2;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
  localparam int S_FRAME = S_HT * S_VT;

  logic        Clck;
  logic        Reset;
  int          checks;
  int          failures;
  int          cyc;
  logic        chk_en;
  logic        paint_en;

  logic [2:0]  fb_f [0:32767];
  logic [2:0]  fb_s [0:32767];

  logic [14:0] addr_f, addr_s;
  logic [2:0]  col_f, col_s;
  logic        r_f, g_f, b_f, hs_f, vs_f, bl_f, ft_f;
  logic        r_s, g_s, b_s, hs_s, vs_s, bl_s, ft_s;

  frame_scanner u_full (
    .Clck(Clck), .Reset(Reset), .mem_address(addr_f), .mem_color(col_f),
    .vga_r(r_f), .vga_g(g_f), .vga_b(b_f), .vga_hs(hs_f), .vga_vs(vs_f),
    .vga_blank_n(bl_f), .frame_tick(ft_f)
  );

  frame_scanner #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SCALE_SHIFT(2)
  ) u_small (
    .Clck(Clck), .Reset(Reset), .mem_address(addr_s), .mem_color(col_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .vga_hs(hs_s), .vga_vs(vs_s),
    .vga_blank_n(bl_s), .frame_tick(ft_s)
  );

  // clock / reset / framebuffer read ports
  initial begin
    Clck = 1'b0;
    forever #10 Clck = ~Clck;
  end

  always @(posedge Clck or negedge Reset) begin
    if (!Reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge Clck) begin
    col_f <= fb_f[addr_f];
    col_s <= fb_s[addr_s];
  end

  function automatic int fbaddr(input int x, input int y);
    return (y / 4) * 160 + (x / 4);
  endfunction

  // Reference model: pixel m is processed on the m-th pixel tick after release;
  // the outputs after that tick describe pixel m-1.
  int          m_cnt, m_clk, out_h, out_v, out_frame;
  logic [14:0] e_addr;
  logic [2:0]  e_rgb;
  logic        e_hs, e_vs, e_bl, e_ft;

  always @(posedge Clck) begin : ref_model
    int pos, h, v, p, ph, pv;
    if (!Reset) begin
      m_clk = 0; m_cnt = 0; e_addr = '0; e_rgb = 3'b000;
      e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_ft = 1'b0;
      out_h = -1; out_v = -1; out_frame = -1;
    end else begin
      m_clk++;
      e_ft = 1'b0;
      if (m_clk >= 2 && (m_clk % 2) == 0) begin
        pos = m_cnt % S_FRAME;
        h = pos % S_HT;
        v = pos / S_HT;
        if (h < S_HV && v < S_VV) e_addr = 15'(fbaddr(h, v));
        if (pos == S_VV * S_HT - 1) e_ft = 1'b1;
        if (m_cnt >= 1) begin
          p = m_cnt - 1;
          ph = (p % S_FRAME) % S_HT;
          pv = (p % S_FRAME) / S_HT;
          out_h = ph; out_v = pv; out_frame = p / S_FRAME;
          e_hs = !(ph >= S_HV + S_HF && ph < S_HV + S_HF + S_HS);
          e_vs = !(pv >= S_VV + S_VF && pv < S_VV + S_VF + S_VS);
          e_bl = (ph < S_HV) && (pv < S_VV);
          e_rgb = e_bl ? fb_s[fbaddr(ph, pv)] : 3'b000;
        end
        m_cnt++;
      end
    end
  end

  // scoreboard: small instance against the model on every clock
  always @(negedge Clck) begin
    if (Reset && chk_en) begin
      checks++;
      if ({addr_s, r_s, g_s, b_s, hs_s, vs_s, bl_s, ft_s} !==
          {e_addr, e_rgb, e_hs, e_vs, e_bl, e_ft}) begin
        failures++;
        $display("FAIL model_small cyc=%0d got addr=%0d rgb=%b hs=%b vs=%b bl=%b ft=%b exp addr=%0d rgb=%b hs=%b vs=%b bl=%b ft=%b",
                 cyc, addr_s, {r_s, g_s, b_s}, hs_s, vs_s, bl_s, ft_s,
                 e_addr, e_rgb, e_hs, e_vs, e_bl, e_ft);
      end
    end
  end

  // edge monitors
  logic hs_f_prev, hs_s_prev, vs_s_prev;
  int   n_hs_fall_f, hs_fall_f0, hs_fall_f1, hs_rise_f;
  int   n_vs_fall_s, vs_fall_s0, vs_fall_s1, vs_rise_s, hs_between_s, ft_cnt_s;

  always @(negedge Clck) begin
    if (!Reset) begin
      n_hs_fall_f = 0; hs_fall_f0 = -1; hs_fall_f1 = -1; hs_rise_f = -1;
      n_vs_fall_s = 0; vs_fall_s0 = -1; vs_fall_s1 = -1; vs_rise_s = -1;
      hs_between_s = 0; ft_cnt_s = 0;
    end else begin
      if (hs_f_prev && !hs_f) begin
        if (n_hs_fall_f == 0) hs_fall_f0 = cyc;
        if (n_hs_fall_f == 1) hs_fall_f1 = cyc;
        n_hs_fall_f++;
      end
      if (!hs_f_prev && hs_f && n_hs_fall_f == 1) hs_rise_f = cyc;
      if (vs_s_prev && !vs_s) begin
        if (n_vs_fall_s == 0) vs_fall_s0 = cyc;
        if (n_vs_fall_s == 1) vs_fall_s1 = cyc;
        n_vs_fall_s++;
      end
      if (!vs_s_prev && vs_s && n_vs_fall_s == 1) vs_rise_s = cyc;
      if (hs_s_prev && !hs_s && n_vs_fall_s == 1) hs_between_s++;
      if (ft_s) ft_cnt_s++;
    end
    hs_f_prev = hs_f;
    hs_s_prev = hs_s;
    vs_s_prev = vs_s;
  end

  // random painter writes, confined to vertical blanking of the small instance
  initial begin
    forever begin
      @(negedge Clck);
      if (paint_en && Reset && (m_cnt % S_FRAME) >= S_VV * S_HT + 3 &&
          (m_cnt % S_FRAME) <= S_FRAME - 3 && $urandom_range(0, 3) == 0)
        fb_s[fbaddr(4 * $urandom_range(0, 3), 4 * $urandom_range(0, 2))] = 3'($urandom);
    end
  end

  // driver tasks
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 20000) begin
      @(negedge Clck);
      g++;
    end
    if (cyc < n) check("wait_cyc_timeout", cyc, n);
  endtask

  task automatic wait_out(input int f, input int x, input int y);
    int g = 0;
    while (!(out_frame == f && out_h == x && out_v == y) && g < 5000) begin
      @(negedge Clck);
      g++;
    end
    if (g >= 5000) check("wait_out_timeout", out_h, x);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_full"}, int'({addr_f, r_f, g_f, b_f, hs_f, vs_f, bl_f, ft_f}),
          int'({15'd0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0}));
    check({tag, "_small"}, int'({addr_s, r_s, g_s, b_s, hs_s, vs_s, bl_s, ft_s}),
          int'({15'd0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0}));
  endtask

  typedef struct {
    int         x;
    int         y;
    logic [14:0] addr;
    logic [2:0] rgb;
    logic       bl;
    logic       hs;
  } vec_t;

  vec_t tbl[6];

  initial begin : main
    int q, g;
    tbl[0] = '{x: 4,   y: 0, addr: 15'd1,   rgb: 3'b001, bl: 1'b1, hs: 1'b1};
    tbl[1] = '{x: 636, y: 1, addr: 15'd159, rgb: 3'b111, bl: 1'b1, hs: 1'b1};
    tbl[2] = '{x: 700, y: 1, addr: 15'd159, rgb: 3'b000, bl: 1'b0, hs: 1'b0};
    tbl[3] = '{x: 324, y: 3, addr: 15'd81,  rgb: 3'b001, bl: 1'b1, hs: 1'b1};
    tbl[4] = '{x: 8,   y: 4, addr: 15'd162, rgb: 3'b010, bl: 1'b1, hs: 1'b1};
    tbl[5] = '{x: 700, y: 4, addr: 15'd319, rgb: 3'b000, bl: 1'b0, hs: 1'b0};

    checks = 0; failures = 0;
    chk_en = 1'b0; paint_en = 1'b0;
    Reset = 1'b0;
    for (int k = 0; k < 32768; k++) begin
      fb_f[k] = 3'(k % 8);
      fb_s[k] = 3'($urandom);
    end
    repeat (5) @(negedge Clck);
    check_reset_vals("reset_state");
    Reset = 1'b1;
    chk_en = 1'b1;
    paint_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      q = tbl[i].y * 800 + tbl[i].x;
      wait_cyc(2 + 2 * q);
      check($sformatf("tbl%0d_addr", i), int'(addr_f), int'(tbl[i].addr));
      wait_cyc(4 + 2 * q);
      check($sformatf("tbl%0d_out", i), int'({r_f, g_f, b_f, bl_f, hs_f}),
            int'({tbl[i].rgb, tbl[i].bl, tbl[i].hs}));
    end

    wait_cyc(3000);
    check("hs_first_fall", hs_fall_f0, 2 * (656 + 1) + 2);
    check("hs_period", hs_fall_f1 - hs_fall_f0, 1600);
    check("hs_low_width", hs_rise_f - hs_fall_f0, 192);

    // Mid-frame reset with the full counters at h=300, v=5.
    wait_cyc(2 + 2 * (5 * 800 + 300 - 1));
    paint_en = 1'b0;
    Reset = 1'b0;
    #1;
    check_reset_vals("midframe_reset");
    for (int k = 0; k < 32768; k++) fb_s[k] = 3'b111;
    repeat (3) @(negedge Clck);
    Reset = 1'b1;

    wait_out(0, 5, 5);
    check("pre_paint_white", int'({r_s, g_s, b_s}), 7);
    g = 0;
    while (!((m_cnt % S_FRAME) >= S_VV * S_HT + 3 && m_cnt / S_FRAME == 0) && g < 2000) begin
      @(negedge Clck);
      g++;
    end
    check("paint_window_reached", int'(g < 2000), 1);
    fb_s[fbaddr(4, 4)] = 3'b001;
    wait_out(1, 5, 5);
    check("painted_blue", int'({r_s, g_s, b_s, bl_s}), 4'b0011);
    wait_out(1, 8, 5);
    check("unpainted_white", int'({r_s, g_s, b_s}), 7);

    wait_cyc(1800);
    check("hs_fall_after_reset", hs_fall_f0, 2 * (656 + 1) + 2);
    check("vs_period", vs_fall_s1 - vs_fall_s0, 2 * S_FRAME);
    check("hs_per_frame", hs_between_s, S_VT);
    check("vs_low_width", vs_rise_s - vs_fall_s0, 2 * S_VS * S_HT);
    check("frame_tick_count", ft_cnt_s, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
